alu_lane_serializer: RTL and testbench

- Sits directly upstream of the integer ALU in each ALU block.
- Accepts one full-warp request (NUM_THREADS lanes of operands plus a shared header) and splits it into NUM_LANES-wide packets.
- Tags each packet with pid/sop/eop and the lowest active lane index (tid), and skips packets whose thread-mask slice is empty.
- The ALU and its commit path use pid/sop/eop and tid to fire the branch on eop and to reassemble the warp result.

---
 rtl/alu_lane_serializer_pkg.sv | 18 +
 rtl/lane_find_next.sv | 23 ++
 rtl/alu_lane_serializer.sv | 138 +++++++++++++
 tb/tb_alu_lane_serializer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_lane_serializer_pkg.sv
// rtl/alu_lane_serializer_pkg.sv - shared types and sizing helpers for the ALU lane serializer
package alu_lane_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int num_packets(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

endpackage

// File: rtl/lane_find_next.sv
// rtl/lane_find_next.sv - next active packet above cur_pid and last-packet flag
module lane_find_next #(
    parameter int NUM_PACKETS = 4,
    parameter int PID_WIDTH   = 2
) (
    input  logic [NUM_PACKETS-1:0] pkt_mask,
    input  logic [PID_WIDTH-1:0]   cur_pid,
    output logic [PID_WIDTH-1:0]   next_pid,
    output logic                   is_last
);

    always_comb begin
        next_pid = '0;
        is_last  = 1'b1;
        for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (pkt_mask[p] && (p > int'(cur_pid))) begin
                next_pid = PID_WIDTH'(p);
                is_last  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_lane_serializer.sv
// rtl/alu_lane_serializer.sv - splits a full-warp request into tagged NUM_LANES-wide packets
module alu_lane_serializer
    import alu_lane_serializer_pkg::*;
#(
    parameter int  NUM_THREADS = 8,
    parameter int  NUM_LANES   = 1,
    parameter int  LANE_DATAW  = 96,
    parameter int  HDRW        = 64,
    localparam int NUM_PACKETS = num_packets(NUM_THREADS, NUM_LANES),
    localparam int PID_WIDTH   = up_clog2(NUM_PACKETS),
    localparam int LANE_WIDTH  = up_clog2(NUM_LANES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic [NUM_THREADS-1:0]            tmask_in,
    input  logic [NUM_THREADS*LANE_DATAW-1:0] data_in,
    input  logic [HDRW-1:0]                   hdr_in,
    output logic                              valid_out,
    input  logic                              ready_out,
    output logic [NUM_LANES-1:0]              tmask_out,
    output logic [NUM_LANES*LANE_DATAW-1:0]   data_out,
    output logic [HDRW-1:0]                   hdr_out,
    output logic [PID_WIDTH-1:0]              pid_out,
    output logic                              sop_out,
    output logic                              eop_out,
    output logic [LANE_WIDTH-1:0]             tid_out
);

    localparam int PKT_DATAW = NUM_LANES * LANE_DATAW;

    state_e                          state_q, state_d;
    logic [PID_WIDTH-1:0]            cur_pid_q, cur_pid_d;
    logic                            sop_q, sop_d;
    logic [NUM_THREADS-1:0]          tmask_q, tmask_d;
    logic [NUM_THREADS*LANE_DATAW-1:0] data_q, data_d;
    logic [HDRW-1:0]                 hdr_q, hdr_d;

    logic [NUM_PACKETS-1:0] pkt_mask, in_pkt_mask;
    logic [PID_WIDTH-1:0]   next_pid, in_first_pid;
    logic [NUM_LANES-1:0]   lane_mask;
    logic [LANE_WIDTH-1:0]  lane_tid;
    logic                   is_last, busy, fire, accept;

    always_comb begin
        pkt_mask    = '0;
        in_pkt_mask = '0;
        for (int p = 0; p < NUM_PACKETS; p++) begin
            pkt_mask[p]    = |tmask_q[p*NUM_LANES +: NUM_LANES];
            in_pkt_mask[p] = |tmask_in[p*NUM_LANES +: NUM_LANES];
        end
    end

    // An all-zero mask leaves first pid at 0, giving one empty packet that still carries eop.
    always_comb begin
        in_first_pid = '0;
        for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (in_pkt_mask[p]) in_first_pid = PID_WIDTH'(p);
        end
    end

    lane_find_next #(
        .NUM_PACKETS(NUM_PACKETS),
        .PID_WIDTH  (PID_WIDTH)
    ) u_find_next (
        .pkt_mask(pkt_mask),
        .cur_pid (cur_pid_q),
        .next_pid(next_pid),
        .is_last (is_last)
    );

    assign busy     = (state_q == BUSY);
    assign fire     = busy & ready_out;
    assign ready_in = !busy | (fire & is_last);
    assign accept   = valid_in & ready_in;

    always_comb begin
        state_d   = state_q;
        cur_pid_d = cur_pid_q;
        sop_d     = sop_q;
        tmask_d   = tmask_q;
        data_d    = data_q;
        hdr_d     = hdr_q;
        if (accept) begin
            state_d   = BUSY;
            cur_pid_d = in_first_pid;
            sop_d     = 1'b1;
            tmask_d   = tmask_in;
            data_d    = data_in;
            hdr_d     = hdr_in;
        end else if (fire && is_last) begin
            state_d   = IDLE;
            cur_pid_d = '0;
            sop_d     = 1'b0;
        end else if (fire) begin
            cur_pid_d = next_pid;
            sop_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_pid_q <= '0;
            sop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_pid_q <= cur_pid_d;
            sop_q     <= sop_d;
        end
    end

    always_ff @(posedge clk) begin
        tmask_q <= tmask_d;
        data_q  <= data_d;
        hdr_q   <= hdr_d;
    end

    assign lane_mask = tmask_q[int'(cur_pid_q)*NUM_LANES +: NUM_LANES];

    always_comb begin
        lane_tid = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--) begin
            if (lane_mask[l]) lane_tid = LANE_WIDTH'(l);
        end
    end

    assign valid_out = busy;
    assign tmask_out = lane_mask;
    assign data_out  = data_q[int'(cur_pid_q)*PKT_DATAW +: PKT_DATAW];
    assign hdr_out   = hdr_q;
    assign pid_out   = cur_pid_q;
    assign sop_out   = busy & sop_q;
    assign eop_out   = busy & is_last;
    assign tid_out   = busy ? lane_tid : '0;

endmodule

// File: tb/tb_alu_lane_serializer.sv
// tb/tb_alu_lane_serializer.sv - directed self-checking bench for alu_lane_serializer
module tb_alu_lane_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  tmask_in;
    logic [63:0] data_in;
    logic [15:0] hdr_in;
    logic        valid_out;
    logic        ready_out;
    logic [1:0]  tmask_out;
    logic [15:0] data_out;
    logic [15:0] hdr_out;
    logic [1:0]  pid_out;
    logic        sop_out;
    logic        eop_out;
    logic        tid_out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_lane_serializer #(
        .NUM_THREADS(8),
        .NUM_LANES  (2),
        .LANE_DATAW (8),
        .HDRW       (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .tmask_in (tmask_in),
        .data_in  (data_in),
        .hdr_in   (hdr_in),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .tmask_out(tmask_out),
        .data_out (data_out),
        .hdr_out  (hdr_out),
        .pid_out  (pid_out),
        .sop_out  (sop_out),
        .eop_out  (eop_out),
        .tid_out  (tid_out)
    );

    task automatic load_req(input logic [7:0] tm, input logic [15:0] h, input logic [7:0] base);
        valid_in = 1'b1;
        tmask_in = tm;
        hdr_in   = h;
        for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic drive_req(input logic [7:0] tm, input logic [15:0] h, input logic [7:0] base);
        load_req(tm, h, base);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] got;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got = {valid_out, pid_out, sop_out, eop_out, tid_out, ready_in};
        vectors++;
        if (got !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", got, 7'b0000001);
        end
        reset = 1'b0;
        @(negedge clk);
        got = {valid_out, pid_out, sop_out, eop_out, tid_out, ready_in};
        vectors++;
        if (got !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_released got=%b exp=%b", got, 7'b0000001);
        end
    endtask

    task automatic test_full_mask;
        logic [8:0]  got, exp;
        logic [15:0] exp_data;
        drive_req(8'hFF, 16'hA001, 8'h10);
        for (int p = 0; p < 4; p++) begin
            got = {valid_out, pid_out, sop_out, eop_out, tmask_out, tid_out, ready_in};
            exp = {1'b1, 2'(p), p == 0, p == 3, 2'b11, 1'b0, p == 3};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL full_pkt%0d got=%b exp=%b", p, got, exp);
            end
            exp_data = {8'h10 + 8'(2*p+1), 8'h10 + 8'(2*p)};
            vectors++;
            if ({data_out, hdr_out} !== {exp_data, 16'hA001}) begin
                errors++;
                $display("FAIL full_data%0d got=%h_%h exp=%h_%h", p, data_out, hdr_out, exp_data, 16'hA001);
            end
            @(negedge clk);
        end
        vectors++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL full_idle got=%b exp=0", valid_out);
        end
    endtask

    task automatic test_sparse;
        logic [8:0] got;
        drive_req(8'b1000_0100, 16'hB002, 8'h20);
        got = {valid_out, pid_out, sop_out, eop_out, tmask_out, tid_out, ready_in};
        vectors++;
        if (got !== 9'b1_01_1_0_01_0_0) begin
            errors++;
            $display("FAIL sparse_pkt1 got=%b exp=%b", got, 9'b1_01_1_0_01_0_0);
        end
        vectors++;
        if (data_out !== 16'h2322) begin
            errors++;
            $display("FAIL sparse_data1 got=%h exp=%h", data_out, 16'h2322);
        end
        @(negedge clk);
        got = {valid_out, pid_out, sop_out, eop_out, tmask_out, tid_out, ready_in};
        vectors++;
        if (got !== 9'b1_11_0_1_10_1_1) begin
            errors++;
            $display("FAIL sparse_pkt3 got=%b exp=%b", got, 9'b1_11_0_1_10_1_1);
        end
        vectors++;
        if (data_out !== 16'h2726) begin
            errors++;
            $display("FAIL sparse_data3 got=%h exp=%h", data_out, 16'h2726);
        end
        @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL sparse_idle got=%b exp=0", valid_out);
        end
    endtask

    task automatic test_empty;
        logic [8:0] got;
        drive_req(8'h00, 16'hC003, 8'h30);
        got = {valid_out, pid_out, sop_out, eop_out, tmask_out, tid_out, ready_in};
        vectors++;
        if (got !== 9'b1_00_1_1_00_0_1) begin
            errors++;
            $display("FAIL empty_pkt got=%b exp=%b", got, 9'b1_00_1_1_00_0_1);
        end
        vectors++;
        if (hdr_out !== 16'hC003) begin
            errors++;
            $display("FAIL empty_hdr got=%h exp=%h", hdr_out, 16'hC003);
        end
        @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL empty_idle got=%b exp=0", valid_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] got;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                got = {valid_out, pid_out, sop_out, eop_out, tmask_out, tid_out, ready_in};
                vectors++;
                if (got !== 9'b1_00_1_1_11_0_1) begin
                    errors++;
                    $display("FAIL b2b_pkt%0d got=%b exp=%b", k, got, 9'b1_00_1_1_11_0_1);
                end
                vectors++;
                if (hdr_out !== 16'hD000 + 16'(k-1)) begin
                    errors++;
                    $display("FAIL b2b_hdr%0d got=%h exp=%h", k, hdr_out, 16'hD000 + 16'(k-1));
                end
            end
            if (k < 4) load_req(8'b0000_0011, 16'hD000 + 16'(k), 8'h40);
            else valid_in = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got=%b exp=0", valid_out);
        end
    endtask

    task automatic test_stall;
        logic [15:0] pat = 16'b1011_0010_0110_0100;
        logic [38:0] got, exp;
        int cnt = 0;
        drive_req(8'hFF, 16'hE004, 8'h70);
        for (int i = 0; i < 16 && cnt < 4; i++) begin
            got = {valid_out, pid_out, sop_out, eop_out, tmask_out, data_out, hdr_out};
            exp = {1'b1, 2'(cnt), cnt == 0, cnt == 3, 2'b11,
                   8'h70 + 8'(2*cnt+1), 8'h70 + 8'(2*cnt), 16'hE004};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall_cyc%0d got=%h exp=%h", i, got, exp);
            end
            ready_out = pat[i];
            if (ready_out) cnt++;
            @(negedge clk);
        end
        ready_out = 1'b1;
        vectors++;
        if ({cnt, valid_out} !== {32'd4, 1'b0}) begin
            errors++;
            $display("FAIL stall_total got=%0d/%b exp=4/0", cnt, valid_out);
        end
    endtask

    task automatic test_reset_mid;
        logic [8:0] got;
        drive_req(8'hFF, 16'hE005, 8'h50);
        @(negedge clk);
        vectors++;
        if ({valid_out, pid_out} !== 3'b1_01) begin
            errors++;
            $display("FAIL rstmid_pid1 got=%b exp=%b", {valid_out, pid_out}, 3'b1_01);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({valid_out, pid_out, sop_out, eop_out, tid_out} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_flush got=%b exp=%b", {valid_out, pid_out, sop_out, eop_out, tid_out}, 6'b0);
        end
        reset = 1'b0;
        drive_req(8'b0011_0000, 16'hE006, 8'h60);
        got = {valid_out, pid_out, sop_out, eop_out, tmask_out, tid_out, ready_in};
        vectors++;
        if (got !== 9'b1_10_1_1_11_0_1) begin
            errors++;
            $display("FAIL rstmid_restart got=%b exp=%b", got, 9'b1_10_1_1_11_0_1);
        end
        vectors++;
        if ({data_out, hdr_out} !== {16'h6564, 16'hE006}) begin
            errors++;
            $display("FAIL rstmid_data got=%h_%h exp=%h_%h", data_out, hdr_out, 16'h6564, 16'hE006);
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        tmask_in  = '0;
        data_in   = '0;
        hdr_in    = '0;
        @(negedge clk);
        test_reset;
        test_full_mask;
        test_sparse;
        test_empty;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
